// File: rtl/key_event_scheduler.sv
// rtl/key_event_scheduler.sv - debounced push-button press-event scheduler
//
// Synchronises and debounces each raw key, turns each press into a single
// event, round-robin arbitrates pending presses into a show-ahead event FIFO
// that the game FSM drains over a valid/ready handshake.
//
// Optional build macro: KEY_REPEAT_EN (auto-repeat while a key is held).
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous assert, synchronous release, active low
//   key             raw asynchronous button levels
//   key_level       debounced levels, 1 = pressed
//   event_valid     event FIFO non-empty
//   event_id        key index at the FIFO head
//   event_ready     consumer accepts the head event
//   overflow        sticky: a press was dropped
//   clear_overflow  synchronous clear of overflow

module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             full;

  assign m_tvalid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = m_tvalid & m_tready;
  // A full FIFO still takes a push in the cycle its head is popped.
  assign s_tready = ~full | pop;
  assign push     = s_tvalid & s_tready;
  // Show-ahead: the head entry is visible without a read strobe. There is no
  // bypass path, so a push into an empty FIFO shows up one cycle later.
  assign m_tdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

module key_event_scheduler #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int IDW            = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                event_valid,
  output logic [IDW-1:0]      event_id,
  input  logic                event_ready,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [DBW-1:0]      db_cnt [NUM_KEYS];

  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pending_nxt;
  logic [NUM_KEYS-1:0] rep_pulse;
  logic                drop;

  logic [IDW-1:0]      rr_ptr;
  logic [IDW:0]        arb_sum;
  logic                grant_found;
  logic [IDW-1:0]      grant_id;
  logic                fifo_ready;
  logic                push;

  // Normalise to 1 = pressed before anything else sees the key.
  assign key_pressed = KEY_ACTIVE_LOW ? ~key : key;
  assign key_level   = stable;

  // Synchroniser, debounce counters and press edge detect. The press pulse is
  // registered so pending flags only ever see a clean single-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press_q  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= key_pressed;
      sync2    <= sync1;
      stable_d <= stable;
      press_q  <= stable & ~stable_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  logic [HW-1:0]       hold_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_armed;

  // rep_armed marks that the first (long) delay has elapsed; from then on the
  // shorter period applies until the key is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_armed <= '0;
      rep_pulse <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!stable[i]) begin
          hold_cnt[i]  <= '0;
          rep_armed[i] <= 1'b0;
        end else if (hold_cnt[i] == (rep_armed[i] ? HW'(REPEAT_PERIOD - 1)
                                                  : HW'(REPEAT_DELAY - 1))) begin
          hold_cnt[i]  <= '0;
          rep_armed[i] <= 1'b1;
          rep_pulse[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_pulse = '0;
`endif

  // Round-robin: first pending bit at or after rr_ptr, wrapping at NUM_KEYS.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_sum     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      arb_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (arb_sum >= (IDW+1)'(NUM_KEYS)) begin
        arb_sum = arb_sum - (IDW+1)'(NUM_KEYS);
      end
      if (!grant_found && pending[arb_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = arb_sum[IDW-1:0];
      end
    end
  end

  assign push = grant_found & fifo_ready;

  // A press is dropped only if its flag would still be set after this
  // cycle's grant; a press arriving as its old flag is granted is kept.
  // Auto-repeats merge into an already-set flag without flagging overflow.
  always_comb begin
    pending_nxt = pending;
    drop        = 1'b0;
    if (push) begin
      pending_nxt[grant_id] = 1'b0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press_q[i]) begin
        if (pending_nxt[i]) begin
          drop = 1'b1;
        end else begin
          pending_nxt[i] = 1'b1;
        end
      end
    end
    pending_nxt = pending_nxt | rep_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (push) begin
        rr_ptr <= (grant_id == IDW'(NUM_KEYS - 1)) ? '0 : grant_id + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDW)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (grant_id),
    .s_tvalid (grant_found),
    .s_tready (fifo_ready),
    .m_tdata  (event_id),
    .m_tvalid (event_valid),
    .m_tready (event_ready)
  );

endmodule
